// File: rtl/frame_buf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : frame_buf_pkg                                              |
// | Description : Shared frame-buffer image constants and writer FSM state   |
// |               type, common to sdram_frame_writer and vga_frame_reader.   |
// | Contents    : IMG_WIDTH_DEF, IMG_HEIGHT_DEF, TOTAL_PIXELS,               |
// |               writer_state_t, burst_len_for()                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package frame_buf_pkg;

  localparam int IMG_WIDTH_DEF  = 320;
  localparam int IMG_HEIGHT_DEF = 240;
  localparam int TOTAL_PIXELS   = IMG_WIDTH_DEF * IMG_HEIGHT_DEF;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FRAME = 3'd1,
    ARM        = 3'd2,
    REQ        = 3'd3,
    BURST      = 3'd4,
    DONE       = 3'd5
  } writer_state_t;

  // Length of the next burst: a full burst unless fewer words remain in the frame.
  function automatic logic [3:0] burst_len_for(input logic [31:0] remaining,
                                               input logic [31:0] burst_max);
    if (remaining < burst_max) begin
      return remaining[3:0];
    end
    return burst_max[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sync_edge_detect                                           |
// | Description : Two-flop synchronizer followed by a rising-edge detector.  |
// |               pulse is high for one clk cycle per rising edge of din.    |
// | Ports       : clk   in  destination clock                                |
// |               rst_n in  asynchronous active-low reset                    |
// |               din   in  asynchronous level                               |
// |               pulse out one-cycle rising-edge strobe                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign pulse = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/sdram_frame_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sdram_frame_writer                                         |
// | Description : Drains the camera FIFO and writes one frame per camera     |
// |               frame_start into SDRAM in linear order using bursts of up  |
// |               to BURST_LEN words. Signals frame completion to readout.   |
// | Option      : DOUBLE_BUFFER_EN - alternate between two frame banks.      |
// | Ports       : clk_sdram, rst_n          clock / async active-low reset   |
// |               sdram_ready               controller init done (sticky)    |
// |               frame_start               camera vsync (asynchronous)      |
// |               fifo_level, fifo_rd_data  show-ahead FIFO read side        |
// |               fifo_rd_en                FIFO pop                         |
// |               wr_req/wr_ack/wr_addr/wr_len  burst command handshake      |
// |               wr_data_req/wr_data       burst data beats                 |
// |               frame_done, frame_error, write_bank  status                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sdram_frame_writer
  import frame_buf_pkg::*;
#(
  parameter int IMG_WIDTH     = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT    = IMG_HEIGHT_DEF,
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 18,
  parameter int BURST_LEN     = 8,
  parameter int FIFO_LW_WIDTH = 10
) (
  input  logic                     clk_sdram,
  input  logic                     rst_n,
  input  logic                     sdram_ready,
  input  logic                     frame_start,
  input  logic [FIFO_LW_WIDTH-1:0] fifo_level,
  input  logic [DATA_WIDTH-1:0]    fifo_rd_data,
  output logic                     fifo_rd_en,
  output logic                     wr_req,
  input  logic                     wr_ack,
  output logic [ADDR_WIDTH-1:0]    wr_addr,
  output logic [3:0]               wr_len,
  input  logic                     wr_data_req,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     frame_done,
  output logic                     frame_error,
  output logic                     write_bank
);

  localparam int                    c_total_pixels = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_WIDTH-1:0] c_total_addr   = ADDR_WIDTH'(c_total_pixels);

  writer_state_t           r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_pixel_count, w_pixel_count_nxt;
  logic [3:0]              r_beats, w_beats_nxt;
  logic [ADDR_WIDTH-1:0]   r_wr_addr, w_wr_addr_nxt;
  logic [3:0]              r_wr_len, w_wr_len_nxt;
  logic                    r_restart, w_restart_nxt;
  logic                    r_frame_error, w_frame_error_nxt;
  logic                    r_ready;
  logic                    w_fs_edge;
  logic [ADDR_WIDTH-1:0]   w_remaining;
  logic [3:0]              w_len;
  logic [ADDR_WIDTH-1:0]   w_base;
  logic [ADDR_WIDTH-1:0]   w_pixel_inc;

  sync_edge_detect u_fs_sync (
    .clk   (clk_sdram),
    .rst_n (rst_n),
    .din   (frame_start),
    .pulse (w_fs_edge)
  );

  assign w_remaining = c_total_addr - r_pixel_count;
  assign w_len       = burst_len_for(32'(w_remaining), 32'(BURST_LEN));
  assign w_pixel_inc = r_pixel_count + ADDR_WIDTH'(1);

`ifdef DOUBLE_BUFFER_EN
  logic r_bank;

  // Bank flips as the frame completes so the reader scans ~write_bank.
  always_ff @(posedge clk_sdram or negedge rst_n) begin
    if (!rst_n) begin
      r_bank <= 1'b0;
    end else if (r_state == DONE) begin
      r_bank <= ~r_bank;
    end
  end

  assign w_base     = r_bank ? c_total_addr : '0;
  assign write_bank = r_bank;
`else
  assign w_base     = '0;
  assign write_bank = 1'b0;
`endif

  always_ff @(posedge clk_sdram or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pixel_count <= '0;
      r_beats       <= '0;
      r_wr_addr     <= '0;
      r_wr_len      <= '0;
      r_restart     <= 1'b0;
      r_frame_error <= 1'b0;
      r_ready       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pixel_count <= w_pixel_count_nxt;
      r_beats       <= w_beats_nxt;
      r_wr_addr     <= w_wr_addr_nxt;
      r_wr_len      <= w_wr_len_nxt;
      r_restart     <= w_restart_nxt;
      r_frame_error <= w_frame_error_nxt;
      r_ready       <= r_ready | sdram_ready;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pixel_count_nxt = r_pixel_count;
    w_beats_nxt       = r_beats;
    w_wr_addr_nxt     = r_wr_addr;
    w_wr_len_nxt      = r_wr_len;
    w_restart_nxt     = r_restart;
    w_frame_error_nxt = r_frame_error;
    wr_req            = 1'b0;
    fifo_rd_en        = 1'b0;
    frame_done        = 1'b0;

    case (r_state)
      IDLE: begin
        if (r_ready) begin
          w_state_nxt = WAIT_FRAME;
        end
      end

      WAIT_FRAME: begin
        if (w_fs_edge) begin
          w_state_nxt       = ARM;
          w_pixel_count_nxt = '0;
        end
      end

      ARM: begin
        // Nothing is in flight here, so a new frame restarts immediately.
        if (w_fs_edge) begin
          w_frame_error_nxt = 1'b1;
          w_pixel_count_nxt = '0;
        end else if (fifo_level >= FIFO_LW_WIDTH'(w_len)) begin
          w_state_nxt   = REQ;
          w_wr_addr_nxt = w_base + r_pixel_count;
          w_wr_len_nxt  = w_len;
        end
      end

      REQ: begin
        wr_req = 1'b1;
        if (w_fs_edge) begin
          w_frame_error_nxt = 1'b1;
          w_restart_nxt     = 1'b1;
        end
        if (wr_ack) begin
          w_state_nxt = BURST;
          w_beats_nxt = r_wr_len;
        end
      end

      BURST: begin
        fifo_rd_en = wr_data_req;
        if (w_fs_edge) begin
          w_frame_error_nxt = 1'b1;
          w_restart_nxt     = 1'b1;
        end
        if (wr_data_req) begin
          w_pixel_count_nxt = w_pixel_inc;
          w_beats_nxt       = r_beats - 4'd1;
          if (r_beats == 4'd1) begin
            // A mid-frame frame_start lets the controller finish this burst,
            // then the same bank is rewritten from pixel 0.
            if (r_restart || w_fs_edge) begin
              w_state_nxt       = ARM;
              w_pixel_count_nxt = '0;
              w_restart_nxt     = 1'b0;
            end else if (w_pixel_inc == c_total_addr) begin
              w_state_nxt = DONE;
            end else begin
              w_state_nxt = ARM;
            end
          end
        end
      end

      DONE: begin
        frame_done = 1'b1;
        if (w_fs_edge) begin
          w_state_nxt       = ARM;
          w_pixel_count_nxt = '0;
        end else begin
          w_state_nxt = WAIT_FRAME;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign wr_addr     = r_wr_addr;
  assign wr_len      = r_wr_len;
  assign wr_data     = fifo_rd_data;
  assign frame_error = r_frame_error;

endmodule
`default_nettype wire

// File: tb/tb_sdram_frame_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sdram_frame_writer                                      |
// | Description : Self-checking bench for sdram_frame_writer on a reduced    |
// |               20x3 frame (last burst is short). Expected bursts are      |
// |               queued per frame and popped at each wr_req.                |
// | Option      : DOUBLE_BUFFER_EN - expected bank/base follow the option.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sdram_frame_writer;

  localparam int W   = 20;
  localparam int H   = 3;
  localparam int TOT = W * H;
  localparam int DW  = 16;
  localparam int AW  = 18;
  localparam int BL  = 8;
  localparam int LW  = 10;
  localparam int NB  = (TOT + BL - 1) / BL;

  logic          clk_sdram   = 1'b0;
  logic          rst_n       = 1'b0;
  logic          sdram_ready = 1'b0;
  logic          frame_start = 1'b0;
  logic [LW-1:0] fifo_level  = '0;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic          wr_req;
  logic          wr_ack      = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_len;
  logic          wr_data_req = 1'b0;
  logic [DW-1:0] wr_data;
  logic          frame_done;
  logic          frame_error;
  logic          write_bank;

  typedef struct {
    int addr;
    int len;
  } burst_t;

  burst_t        sb[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            exp_bank = 0;
  logic [DW-1:0] exp_word = '0;
  logic [DW-1:0] fifo_head = '0;

  always #5 clk_sdram = ~clk_sdram;

  // Show-ahead FIFO model: the head advances by one word per pop.
  assign fifo_rd_data = fifo_head;
  always @(posedge clk_sdram) begin
    if (fifo_rd_en) fifo_head <= fifo_head + 16'd1;
  end

  sdram_frame_writer #(
    .IMG_WIDTH     (W),
    .IMG_HEIGHT    (H),
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .BURST_LEN     (BL),
    .FIFO_LW_WIDTH (LW)
  ) dut (
    .clk_sdram    (clk_sdram),
    .rst_n        (rst_n),
    .sdram_ready  (sdram_ready),
    .frame_start  (frame_start),
    .fifo_level   (fifo_level),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .wr_req       (wr_req),
    .wr_ack       (wr_ack),
    .wr_addr      (wr_addr),
    .wr_len       (wr_len),
    .wr_data_req  (wr_data_req),
    .wr_data      (wr_data),
    .frame_done   (frame_done),
    .frame_error  (frame_error),
    .write_bank   (write_bank)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int base_addr();
`ifdef DOUBLE_BUFFER_EN
    return (exp_bank != 0) ? TOT : 0;
`else
    return 0;
`endif
  endfunction

  task automatic next_bank();
`ifdef DOUBLE_BUFFER_EN
    exp_bank = 1 - exp_bank;
`endif
  endtask

  task automatic push_frame();
    burst_t b;
    for (int p = 0; p < TOT; p += BL) begin
      b.addr = base_addr() + p;
      b.len  = ((TOT - p) < BL) ? (TOT - p) : BL;
      sb.push_back(b);
    end
  endtask

  task automatic pulse_fs();
    @(negedge clk_sdram);
    frame_start = 1'b1;
    repeat (3) @(negedge clk_sdram);
    frame_start = 1'b0;
  endtask

  // One burst as seen by the controller. abort_beat raises frame_start at
  // that beat; reset_beat asserts rst_n low at that beat instead of completing.
  task automatic do_burst(input int ack_delay, input int abort_beat, input int reset_beat);
    burst_t e;
    bit     got;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk_sdram);
      if (wr_req) got = 1'b1;
    end
    check("req_seen", 32'(got), 32'd1);
    if (!got) return;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL sb_underflow: observed request at %0h expected none", wr_addr);
      return;
    end
    e = sb.pop_front();
    check("wr_addr", 32'(wr_addr), 32'(e.addr));
    check("wr_len", 32'(wr_len), 32'(e.len));
    for (int d = 0; d < ack_delay; d++) begin
      @(negedge clk_sdram);
      check("req_hold", 32'(wr_req), 32'd1);
      check("addr_hold", 32'(wr_addr), 32'(e.addr));
      check("len_hold", 32'(wr_len), 32'(e.len));
      check("no_pop_req", 32'(fifo_rd_en), 32'd0);
    end
    wr_ack = 1'b1;
    @(negedge clk_sdram);
    wr_ack = 1'b0;
    #1 check("no_pop_pre_data", 32'(fifo_rd_en), 32'd0);
    for (int b = 0; b < e.len; b++) begin
      wr_data_req = 1'b1;
      if (b == reset_beat) begin
        rst_n = 1'b0;
        #1;
        check("rst_wr_req", 32'(wr_req), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_error", 32'(frame_error), 32'd0);
        check("rst_bank", 32'(write_bank), 32'd0);
        check("rst_addr", 32'(wr_addr), 32'd0);
        check("rst_len", 32'(wr_len), 32'd0);
        wr_data_req = 1'b0;
        sb.delete();
        return;
      end
      if (b == abort_beat) frame_start = 1'b1;
      if (b == abort_beat + 3) frame_start = 1'b0;
      #1;
      check("pop_beat", 32'(fifo_rd_en), 32'd1);
      check("wr_data", 32'(wr_data), 32'(exp_word));
      exp_word = exp_word + 16'd1;
      @(negedge clk_sdram);
    end
    wr_data_req = 1'b0;
    frame_start = 1'b0;
  endtask

  // Counts frame_done pulses over the current and next four cycles.
  task automatic check_done(input int exp_pulses);
    int cnt;
    cnt = int'(frame_done);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sdram);
      cnt += int'(frame_done);
    end
    check("frame_done_count", 32'(cnt), 32'(exp_pulses));
  endtask

  task automatic run_bursts(input int n, input int ack_delay);
    for (int k = 0; k < n; k++) do_burst(ack_delay, -1, -1);
  endtask

  initial begin
    int hi;

    // Reset state
    repeat (3) @(negedge clk_sdram);
    check("reset_wr_req", 32'(wr_req), 32'd0);
    check("reset_rd_en", 32'(fifo_rd_en), 32'd0);
    check("reset_done", 32'(frame_done), 32'd0);
    check("reset_error", 32'(frame_error), 32'd0);
    check("reset_bank", 32'(write_bank), 32'd0);
    check("reset_addr", 32'(wr_addr), 32'd0);
    check("reset_len", 32'(wr_len), 32'd0);
    rst_n = 1'b1;

    // frame_start before sdram_ready is ignored; ready latches from a 1-cycle pulse
    fifo_level = 10'd512;
    pulse_fs();
    repeat (10) @(negedge clk_sdram);
    check("idle_no_req", 32'(wr_req), 32'd0);
    sdram_ready = 1'b1;
    @(negedge clk_sdram);
    sdram_ready = 1'b0;
    repeat (8) @(negedge clk_sdram);
    check("wait_no_req", 32'(wr_req), 32'd0);

    // Full frame, FIFO always full, immediate ack
    pulse_fs();
    push_frame();
    run_bursts(NB, 0);
    check_done(1);
    check("f1_sb_empty", 32'(sb.size()), 32'd0);
    check("f1_no_error", 32'(frame_error), 32'd0);
    next_bank();
    check("f1_bank", 32'(write_bank), 32'(exp_bank));

    // FIFO level one short of a burst holds off the request
    fifo_level = 10'd7;
    pulse_fs();
    push_frame();
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_sdram);
      hi += int'(wr_req);
    end
    check("lvl7_no_req", 32'(hi), 32'd0);
    fifo_level = 10'd8;
    @(negedge clk_sdram);
    check("lvl8_req", 32'(wr_req), 32'd1);
    // Delayed ack: command stays stable, nothing popped before data
    do_burst(5, -1, -1);
    fifo_level = 10'd512;
    run_bursts(NB - 1, 2);
    check_done(1);
    next_bank();
    check("f2_bank", 32'(write_bank), 32'(exp_bank));

    // frame_start mid-burst: burst finishes, frame restarts at 0, no frame_done
    pulse_fs();
    push_frame();
    run_bursts(3, 0);
    do_burst(0, 2, -1);
    check("abort_error", 32'(frame_error), 32'd1);
    sb.delete();
    push_frame();
    check_done(0);
    run_bursts(NB, 0);
    check_done(1);
    check("error_sticky", 32'(frame_error), 32'd1);
    next_bank();
    check("f3_bank", 32'(write_bank), 32'(exp_bank));

    // Async reset mid-burst clears everything in the same cycle
    pulse_fs();
    push_frame();
    run_bursts(1, 0);
    do_burst(0, -1, 3);
    exp_bank = 0;
    @(negedge clk_sdram);
    rst_n = 1'b1;

    // After reset the ready latch is clear again: early frame_start ignored
    pulse_fs();
    repeat (10) @(negedge clk_sdram);
    check("post_rst_idle", 32'(wr_req), 32'd0);
    sdram_ready = 1'b1;
    repeat (8) @(negedge clk_sdram);
    check("post_rst_wait", 32'(wr_req), 32'd0);
    pulse_fs();
    push_frame();
    do_burst(0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
